// File: rtl/id_hazard_tracker.sv
// -----------------------------------------------------------------------------
// id_hazard_tracker
//
// ID-stage hazard unit. It keeps a shift register of the destination registers
// of the instructions in flight in the back-end stages (entry 0 = EX). From
// that it derives:
//   - forwarding selects for rs1 and rs2,
//   - a load-use / no-bypass stall,
//   - a saturating count of counted stall cycles.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   id_valid                ID holds a real instruction
//   id_rs1, id_rs1_used     source 1 index and read enable
//   id_rs2, id_rs2_used     source 2 index and read enable
//   id_rd, id_rd_wr         destination index and write enable
//   id_is_load              ID instruction is a load
//   flush                   ID instruction is killed this cycle
//   hold                    back-end frozen; tracker does not advance
//   stall                   freeze PC and IF/ID, bubble into EX
//   fwd_sel_rs1/rs2         0 = regfile, k+1 = forward from entry k
//   stall_cnt               cycles with stall=1 and hold=0, saturating
//
// stall and fwd_sel depend only on the tracker registers and the ID operand
// fields. flush and hold feed only the next-state logic, so neither has a
// combinational path to stall or fwd_sel.
// -----------------------------------------------------------------------------
module id_hazard_tracker #(
    parameter int NUM_STAGES       = 3,
    parameter int LOAD_READY_STAGE = 1,
    parameter int FWD_EN           = 1,
    parameter int CNT_W            = 32,
    localparam int FW              = $clog2(NUM_STAGES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic             id_rs1_used,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs2_used,
    input  logic [4:0]       id_rd,
    input  logic             id_rd_wr,
    input  logic             id_is_load,
    input  logic             flush,
    input  logic             hold,
    output logic             stall,
    output logic [FW-1:0]    fwd_sel_rs1,
    output logic [FW-1:0]    fwd_sel_rs2,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [FW-1:0]    LOAD_READY_IDX = FW'(LOAD_READY_STAGE);
    localparam logic [CNT_W-1:0] CNT_MAX        = {CNT_W{1'b1}};

    // Tracker state: one {v, rd, ld} entry per back-end stage.
    logic [NUM_STAGES-1:0] ent_v_r;
    logic [NUM_STAGES-1:0] ent_ld_r;
    logic [4:0]            ent_rd_r [NUM_STAGES];
    logic [CNT_W-1:0]      stall_cnt_r;

    // Per-source lookup results (index 0 = rs1, index 1 = rs2).
    logic [4:0]    src_s [2];
    logic [1:0]    src_live_s;
    logic [1:0]    hit_s;
    logic [1:0]    hit_ld_s;
    logic [1:0]    early_s;
    logic [FW-1:0] idx_s [2];
    logic [1:0]    src_stall_s;
    logic          stall_s;
    logic          ins_s;

    // Source operands and liveness; x0 is never a dependency.
    always_comb begin
        src_s[0]      = id_rs1;
        src_s[1]      = id_rs2;
        src_live_s[0] = id_valid & id_rs1_used & (id_rs1 != 5'd0);
        src_live_s[1] = id_valid & id_rs2_used & (id_rs2 != 5'd0);
    end

    // Youngest-match search: scan oldest to youngest so the lowest index wins.
    // early_s flags any match that is not yet in the last (write-through) entry.
    always_comb begin
        hit_s    = 2'b00;
        hit_ld_s = 2'b00;
        early_s  = 2'b00;
        idx_s[0] = '0;
        idx_s[1] = '0;
        for (int j = 0; j < 2; j++) begin
            for (int k = NUM_STAGES - 1; k >= 0; k--) begin
                if (src_live_s[j] && ent_v_r[k] && (ent_rd_r[k] == src_s[j])) begin
                    hit_s[j]    = 1'b1;
                    idx_s[j]    = FW'(k);
                    hit_ld_s[j] = ent_ld_r[k];
                    if (k < NUM_STAGES - 1) begin
                        early_s[j] = 1'b1;
                    end else begin
                        early_s[j] = early_s[j];
                    end
                end else begin
                    hit_s[j] = hit_s[j];
                end
            end
        end
    end

    // Stall terms: with a bypass only an unready load stalls; without one,
    // anything short of the write-through entry stalls.
    always_comb begin
        src_stall_s = 2'b00;
        for (int j = 0; j < 2; j++) begin
            if (FWD_EN != 0) begin
                src_stall_s[j] = hit_s[j] & hit_ld_s[j] & (idx_s[j] < LOAD_READY_IDX);
            end else begin
                src_stall_s[j] = early_s[j];
            end
        end
        stall_s = |src_stall_s;
    end

    // Forwarding selects; always 0 when there is no bypass network.
    always_comb begin
        fwd_sel_rs1 = '0;
        fwd_sel_rs2 = '0;
        if ((FWD_EN != 0) && hit_s[0]) begin
            fwd_sel_rs1 = idx_s[0] + FW'(1);
        end else begin
            fwd_sel_rs1 = '0;
        end
        if ((FWD_EN != 0) && hit_s[1]) begin
            fwd_sel_rs2 = idx_s[1] + FW'(1);
        end else begin
            fwd_sel_rs2 = '0;
        end
    end

    // A stalled or flushed instruction enters EX as a bubble.
    always_comb begin
        ins_s = id_valid & ~stall_s & ~flush & id_rd_wr & (id_rd != 5'd0);
    end

    // Tracker shift register; hold freezes every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_v_r  <= '0;
            ent_ld_r <= '0;
            for (int k = 0; k < NUM_STAGES; k++) begin
                ent_rd_r[k] <= 5'd0;
            end
        end else if (!hold) begin
            ent_v_r  <= {ent_v_r[NUM_STAGES-2:0], ins_s};
            ent_ld_r <= {ent_ld_r[NUM_STAGES-2:0], ins_s & id_is_load};
            for (int k = NUM_STAGES - 1; k >= 1; k--) begin
                ent_rd_r[k] <= ent_rd_r[k-1];
            end
            ent_rd_r[0] <= ins_s ? id_rd : 5'd0;
        end
    end

    // Saturating stall-cycle counter; frozen cycles are not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= '0;
        end else if (stall_s && !hold && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall     = stall_s;
    assign stall_cnt = stall_cnt_r;

endmodule
